// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder clocked by the system clock.
// sck/mosi/ncs are synchronized and edge-detected internally. Received bytes
// are presented as single-cycle strobes. Transmit bytes come from a
// single-entry holding buffer; when that buffer is empty, FILL is sent instead.
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL        = 8'hFF
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sck_hist;
    logic                   r_ncs_hist;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [7:0] r_tx_buf;
    logic       r_tx_empty;

    logic       w_sck;
    logic       w_mosi;
    logic       w_ncs;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_ncs_rise;
    logic       w_ncs_fall;
    logic       w_start;
    logic       w_reload;
    logic       w_consume;
    logic [7:0] w_tx_src;
    logic [7:0] w_rx_next;

    // Synchronizer chains plus one history flop for edge detection.
    // ncs resets high so that leaving reset does not look like a select.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sck_hist  <= 1'b0;
            r_ncs_hist  <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sck_hist  <= r_sck_sync[SYNC_STAGES-1];
            r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_ncs      = r_ncs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_hist;
    assign w_sck_fall = ~w_sck & r_sck_hist;
    assign w_ncs_rise = w_ncs & ~r_ncs_hist;
    assign w_ncs_fall = ~w_ncs & r_ncs_hist;

    // Loading the shift register consumes the holding buffer. That happens at
    // select, and again at every byte-boundary falling edge. A deselect in the
    // same cycle suppresses the reload, so the pending byte survives.
    assign w_start   = (r_state == IDLE) && w_ncs_fall;
    assign w_reload  = (r_state == SHIFT) && w_sck_fall && (r_cnt == 3'd0) && !w_ncs_rise;
    assign w_consume = w_start || w_reload;
    assign w_tx_src  = r_tx_empty ? FILL : r_tx_buf;
    assign w_rx_next = {r_rx_shift[6:0], w_mosi};

    // Holding buffer: a load always wins over a coincident consume. The consume
    // still takes the old contents, through w_tx_src.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_tx_buf   <= FILL;
            r_tx_empty <= 1'b1;
        end else if (tx_load) begin
            r_tx_buf   <= tx_data;
            r_tx_empty <= 1'b0;
        end else if (w_consume) begin
            r_tx_empty <= 1'b1;
        end
    end

    // Transfer FSM. miso is bit 7 of the tx shift register, which is held at
    // all-ones while deselected.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'hFF;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt      <= 3'd0;
                    r_tx_shift <= 8'hFF;
                    if (w_ncs_fall) begin
                        r_state    <= SHIFT;
                        r_tx_shift <= w_tx_src;
                    end
                end
                SHIFT: begin
                    if (w_sck_rise) begin
                        r_rx_shift <= w_rx_next;
                        r_cnt      <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                        end
                    end
                    if (w_reload) begin
                        r_tx_shift <= w_tx_src;
                    end else if (w_sck_fall && (r_cnt != 3'd0)) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                    end
                    // A byte completing in this same cycle has already been
                    // latched above. Any partial byte is simply dropped.
                    if (w_ncs_rise) begin
                        r_state    <= IDLE;
                        r_cnt      <= 3'd0;
                        r_tx_shift <= 8'hFF;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign miso     = r_tx_shift[7];
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_empty = r_tx_empty;
    assign busy     = ~w_ncs;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: it drives the SPI pins as a mode-0 master. A
// transaction-level model predicts the bytes returned on miso and the bytes
// that rx_valid will strobe out.
module tb_spi_responder;

    localparam int         HALF = 8;
    localparam logic [7:0] FILL = 8'hFF;

    logic       clock   = 1'b0;
    logic       rst     = 1'b0;
    logic       sck     = 1'b0;
    logic       mosi    = 1'b0;
    logic       ncs     = 1'b1;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic       rx_valid;
    logic       tx_empty;
    logic       busy;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one pending tx byte (or none) and the rx bytes still expected.
    logic [7:0] m_buf   = 8'h00;
    bit         m_valid = 1'b0;
    logic [7:0] rxq[$];
    bit         prev_valid = 1'b0;

    spi_responder #(.SYNC_STAGES(2), .FILL(FILL)) dut (
        .clock(clock), .rst(rst), .sck(sck), .mosi(mosi), .ncs(ncs),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // The shift register takes the pending byte, or FILL when nothing is pending.
    function automatic logic [7:0] consume();
        logic [7:0] v;
        v = m_valid ? m_buf : FILL;
        m_valid = 1'b0;
        return v;
    endfunction

    task automatic load(input logic [7:0] v);
        tx_data = v; tx_load = 1'b1; m_buf = v; m_valid = 1'b1;
        clk(1);
        tx_load = 1'b0;
        clk(2);
    endtask

    task automatic reset_checks(input string tag);
        chk1({tag, "_miso"}, miso, 1'b1);
        chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk1({tag, "_tx_empty"}, tx_empty, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk8({tag, "_rx_data"}, rx_data, 8'h00);
    endtask

    // Sends nbits of one byte. miso is sampled at the end of each low phase,
    // i.e. just before the rising edge where the master would take it.
    task automatic xfer(input logic [7:0] mo, input logic [7:0] exp, input int nbits,
                        input bit do_load, input logic [7:0] lv);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            if (do_load && i == 3) begin
                tx_data = lv; tx_load = 1'b1; m_buf = lv; m_valid = 1'b1;
                clk(1);
                tx_load = 1'b0;
                clk(HALF - 1);
            end else begin
                clk(HALF);
            end
            chk1("miso_bit", miso, exp[7-i]);
            chk1("busy_active", busy, 1'b1);
            if (i == 0) chk1("tx_empty_at_byte_start", tx_empty, !m_valid);
            sck = 1'b1;
            clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frame(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                         input int nbits, input int load_byte, input logic [7:0] load_val);
        logic [7:0] mo;
        logic [7:0] exp;
        ncs = 1'b0;
        exp = consume();
        for (int k = 0; k < nb; k++) begin
            mo = (k == 0) ? b0 : b1;
            if (nbits == 8) rxq.push_back(mo);
            xfer(mo, exp, nbits, k == load_byte, load_val);
            // A full byte's trailing falling edge reloads from the buffer.
            if (nbits == 8) exp = consume();
        end
        clk(HALF);
        ncs = 1'b1;
        clk(3 * HALF);
        chk1("busy_after_frame", busy, 1'b0);
        chk1("miso_idle", miso, 1'b1);
    endtask

    // Every rx_valid strobe must be a single cycle wide and must deliver the
    // next expected byte.
    always @(negedge clock) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid) begin
                chk1("rx_valid_single_cycle", prev_valid, 1'b0);
                if (rxq.size() == 0) chk1("rx_valid_unexpected", rx_valid, 1'b0);
                else chk8("rx_data_stream", rx_data, rxq.pop_front());
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        // 1: reset with the pins idle
        #2 rst = 1'b1;
        clk(3);
        reset_checks("reset");
        rst = 1'b0;
        clk(4);
        reset_checks("post_reset");

        // 2: preloaded A5 is returned while 3C is received
        load(8'hA5);
        chk1("t2_tx_empty_loaded", tx_empty, 1'b0);
        frame(1, 8'h3C, 8'h00, 8, -1, 8'h00);
        chk8("t2_rx_data", rx_data, 8'h3C);
        chk1("t2_tx_empty", tx_empty, 1'b1);

        // 3: nothing loaded, so FILL goes out
        frame(1, 8'h00, 8'h00, 8, -1, 8'h00);
        chk8("t3_rx_data", rx_data, 8'h00);

        // 4: two-byte burst, with a load during byte 1 feeding byte 2
        frame(2, 8'h12, 8'h34, 8, 0, 8'h56);
        chk8("t4_rx_data", rx_data, 8'h34);

        // 5: aborted after 5 bits, then a clean byte
        frame(1, 8'hA7, 8'h00, 5, -1, 8'h00);
        chk8("t5_no_update", rx_data, 8'h34);
        frame(1, 8'h81, 8'h00, 8, -1, 8'h00);
        chk8("t5_rx_data", rx_data, 8'h81);

        // 6: asynchronous reset mid-byte while a tx byte is pending
        ncs = 1'b0;
        xfer(8'hF0, consume(), 4, 1'b1, 8'h77);
        chk1("t6_tx_pending", tx_empty, 1'b0);
        clk(2);
        #2 rst = 1'b1;
        #1 reset_checks("t6_async");
        m_valid = 1'b0;
        ncs = 1'b1;
        clk(3);
        rst = 1'b0;
        clk(4);
        chk1("t6_tx_empty_after", tx_empty, 1'b1);
        frame(1, 8'h5A, 8'h00, 8, -1, 8'h00);
        chk8("t6_rx_data", rx_data, 8'h5A);

        clk(4);
        chk1("rx_queue_drained", rxq.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
